// File: rtl/laser_burst_controller.sv
// ---------------------------------------------------------------------------
// laser_burst_controller
// Fires the break-beam laser as bursts of ON/OFF pulses and scores the paired
// receiver. A pulse is a hit when rx_in is high on the last ON cycle and low
// on the last OFF cycle, so ambient light and a stuck receiver both read as
// misses. Each completed burst publishes its hit count and a beam-broken flag.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   level, 1 = run bursts continuously
//   rx_in        in   receiver level, already synchronous to clk
//   laser        out  laser drive (registered)
//   burst_done   out  one-cycle strobe when a burst result is published
//   hit_count    out  hits in the last completed burst (held)
//   beam_broken  out  last completed burst had hit_count < HIT_MIN (held)
//   busy         out  high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module laser_burst_controller #(
  parameter int unsigned ON_CYC  = 50,
  parameter int unsigned OFF_CYC = 50,
  parameter int unsigned PULSES  = 8,
  parameter int unsigned GAP_CYC = 1000,
  parameter int unsigned HIT_MIN = 6,
  parameter int unsigned CW      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       rx_in,
  output logic       laser,
  output logic       burst_done,
  output logic [7:0] hit_count,
  output logic       beam_broken,
  output logic       busy
);

  localparam int unsigned IW = 8;

  localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] OFF_LAST  = CW'(OFF_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(PULSES - 1);
  localparam logic [IW-1:0] HIT_MIN_V = IW'(HIT_MIN);
  localparam logic [IW-1:0] ACC_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] acc_q, acc_d;
  logic          on_ok_q, on_ok_d;
  logic [IW-1:0] hit_q, hit_d;
  logic          broken_q, broken_d;
  logic          done_q, done_d;
  logic          laser_q, laser_d;
  logic          busy_q, busy_d;

  logic [IW-1:0] acc_next_c;
  logic          pulse_hit_c;

  // State and output registers; reset drops the laser immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      on_ok_q  <= 1'b0;
      hit_q    <= '0;
      broken_q <= 1'b0;
      done_q   <= 1'b0;
      laser_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      on_ok_q  <= on_ok_d;
      hit_q    <= hit_d;
      broken_q <= broken_d;
      done_q   <= done_d;
      laser_q  <= laser_d;
      busy_q   <= busy_d;
    end
  end

  // Pulse scoring: saturating accumulator value if this OFF phase ends now.
  always_comb begin
    pulse_hit_c = on_ok_q & ~rx_in;
    acc_next_c  = acc_q;
    if (pulse_hit_c && (acc_q != ACC_MAX)) begin
      acc_next_c = acc_q + IW'(1);
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    acc_d    = acc_q;
    on_ok_d  = on_ok_q;
    hit_d    = hit_q;
    broken_d = broken_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        acc_d = '0;
        if (enable) begin
          state_d = S_ON;
        end
      end

      S_ON: begin
        if (!enable) begin
          // Abandon the partial burst; published status is left untouched.
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          acc_d   = '0;
        end else if (cnt_q == ON_LAST) begin
          on_ok_d = rx_in;
          state_d = S_OFF;
          cnt_d   = '0;
        end
      end

      S_OFF: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          acc_d   = '0;
        end else if (cnt_q == OFF_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            // Burst complete: publish and start the inter-burst gap.
            state_d  = S_GAP;
            hit_d    = acc_next_c;
            broken_d = (acc_next_c < HIT_MIN_V);
            done_d   = 1'b1;
            acc_d    = '0;
            idx_d    = '0;
          end else begin
            state_d = S_ON;
            acc_d   = acc_next_c;
            idx_d   = idx_q + IW'(1);
          end
        end
      end

      S_GAP: begin
        // The gap always runs to completion, even with enable low.
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = enable ? S_ON : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Laser follows the ON state exactly, so it cannot outlast ON_CYC cycles.
    laser_d = (state_d == S_ON);
    busy_d  = (state_d != S_IDLE);
  end

  assign laser       = laser_q;
  assign burst_done  = done_q;
  assign hit_count   = hit_q;
  assign beam_broken = broken_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_laser_burst_controller.sv
// ---------------------------------------------------------------------------
// tb_laser_burst_controller
// Directed scenarios plus randomized rx/enable traffic. A cycle-position model
// (position within a burst, plain arithmetic) predicts every output on every
// cycle; literal expectations pin the model on the key scenarios.
// ---------------------------------------------------------------------------
module tb_laser_burst_controller;

  localparam int ON   = 4;
  localparam int OFF  = 4;
  localparam int P    = 3;
  localparam int GAP  = 10;
  localparam int HMIN = 2;
  localparam int T    = ON + OFF;
  localparam int PT   = P * T;
  localparam int L    = PT + GAP;

  localparam int M_ECHO = 0;
  localparam int M_LOW  = 1;
  localparam int M_HIGH = 2;
  localparam int M_MASK = 3;
  localparam int M_RAND = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       rx_in = 1'b0;
  logic       laser;
  logic       burst_done;
  logic [7:0] hit_count;
  logic       beam_broken;
  logic       busy;

  int checks = 0;
  int failures = 0;

  laser_burst_controller #(
    .ON_CYC (ON),
    .OFF_CYC(OFF),
    .PULSES (P),
    .GAP_CYC(GAP),
    .HIT_MIN(HMIN),
    .CW     (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .rx_in      (rx_in),
    .laser      (laser),
    .burst_done (burst_done),
    .hit_count  (hit_count),
    .beam_broken(beam_broken),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: running flag plus position m_p within the burst period.
  bit m_run    = 1'b0;
  int m_p      = 0;
  int m_acc    = 0;
  bit m_onok   = 1'b0;
  int m_hit    = 0;
  bit m_broken = 1'b0;
  bit m_done   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_p = 0; m_acc = 0; m_onok = 0;
      m_hit = 0; m_broken = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (enable) begin
          m_run = 1; m_p = 0; m_acc = 0;
        end
      end else if (m_p < PT) begin
        if (!enable) begin
          m_run = 0; m_acc = 0;
        end else begin
          if (m_p % T == ON - 1) m_onok = rx_in;
          if (m_p % T == T - 1 && m_onok && !rx_in && m_acc < 255) m_acc++;
          if (m_p == PT - 1) begin
            m_hit = m_acc; m_broken = (m_acc < HMIN); m_done = 1; m_acc = 0;
          end
          m_p++;
        end
      end else begin
        if (m_p == L - 1) begin
          if (enable) m_p = 0;
          else m_run = 0;
        end else begin
          m_p++;
        end
      end
    end
  end

  // Receiver stimulus, changed just after each rising edge.
  int rx_mode = M_ECHO;
  bit last_laser = 1'b0;

  always @(posedge clk) begin
    #2;
    case (rx_mode)
      M_ECHO: rx_in = last_laser;
      M_LOW:  rx_in = 1'b0;
      M_HIGH: rx_in = 1'b1;
      M_MASK: rx_in = (m_p >= T && m_p < 3 * T) ? 1'b0 : last_laser;
      default: rx_in = 1'($urandom_range(0, 1));
    endcase
    last_laser = laser;
  end

  // Per-cycle comparison against the model, plus the laser on-time bound.
  bit chk_en = 1'b0;
  int run_len = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("laser", int'(laser), int'(m_run && m_p < PT && (m_p % T) < ON));
      check("busy", int'(busy), int'(m_run));
      check("burst_done", int'(burst_done), int'(m_done));
      check("hit_count", int'(hit_count), m_hit);
      check("beam_broken", int'(beam_broken), int'(m_broken));
      run_len = laser ? run_len + 1 : 0;
      check("laser_on_run_le_ON", int'(run_len <= ON), 1);
    end
  end

  task automatic wait_done(input int bound, output int n);
    bit ok;
    ok = 0;
    n = 0;
    while (n < bound && !ok) begin
      @(negedge clk);
      n++;
      if (burst_done) ok = 1;
    end
    check("burst_done_seen", int'(ok), 1);
  endtask

  task automatic wait_laser(input int bound, output int n);
    bit ok;
    ok = 0;
    n = 0;
    while (n < bound && !ok) begin
      @(negedge clk);
      n++;
      if (laser) ok = 1;
    end
    check("laser_seen", int'(ok), 1);
  endtask

  initial begin
    int n;
    int rises;
    int dones;
    bit prev;

    // 1. Reset and idle.
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_laser", int'(laser), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_hit", int'(hit_count), 0);
    check("idle_broken", int'(beam_broken), 0);

    // 2. Clean echo: result published 24 cycles after the sampling edge.
    rx_mode = M_ECHO;
    enable = 1'b1;
    wait_done(100, n);
    check("done_latency", n, 25);
    check("echo_hit", int'(hit_count), 3);
    check("echo_broken", int'(beam_broken), 0);
    wait_laser(60, n);
    check("gap_to_next_burst", n, 10);
    wait_done(60, n);

    // 3. Receiver stuck low, then ambient high.
    rx_mode = M_LOW;
    wait_done(60, n);
    check("low_hit", int'(hit_count), 0);
    check("low_broken", int'(beam_broken), 1);
    rx_mode = M_HIGH;
    wait_done(60, n);
    check("high_hit", int'(hit_count), 0);
    check("high_broken", int'(beam_broken), 1);

    // 4. Pulses 2 and 3 blocked, then a clean burst.
    rx_mode = M_MASK;
    wait_done(60, n);
    check("mask_hit", int'(hit_count), 1);
    check("mask_broken", int'(beam_broken), 1);
    rx_mode = M_ECHO;
    wait_done(60, n);
    check("clean_hit", int'(hit_count), 3);
    check("clean_broken", int'(beam_broken), 0);

    // 5. Disable during the second ON phase.
    rises = 0;
    n = 0;
    prev = laser;
    while (rises < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (laser && !prev) rises++;
      prev = laser;
    end
    check("second_pulse_found", rises, 2);
    enable = 1'b0;
    @(negedge clk);
    check("abort_laser", int'(laser), 0);
    check("abort_busy", int'(busy), 0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (burst_done) dones++;
    end
    check("abort_no_done", dones, 0);
    check("abort_hit_held", int'(hit_count), 3);
    check("abort_broken_held", int'(beam_broken), 0);
    enable = 1'b1;
    wait_done(100, n);
    check("fresh_burst_latency", n, 25);
    check("fresh_hit", int'(hit_count), 3);

    // Randomized receiver and enable traffic.
    rx_mode = M_RAND;
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
    end

    // 6. Asynchronous reset during an ON phase.
    enable = 1'b1;
    rx_mode = M_ECHO;
    wait_laser(100, n);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_laser", int'(laser), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(burst_done), 0);
    check("rst_hit", int'(hit_count), 0);
    check("rst_broken", int'(beam_broken), 0);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
